// File: rtl/mult_datapath.sv
// mult_datapath: shift-add multiplier datapath with registered product and valid pulse.
// Define SIGNED_MULT_EN for two's complement operands via sign-magnitude.
module mult_datapath #(
    parameter int WIDTH = 16
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic [WIDTH-1:0]   i_operand_a,
    input  logic [WIDTH-1:0]   i_operand_b,
    input  logic [1:0]         i_reg_a_mode,
    input  logic [1:0]         i_reg_b_mode,
    input  logic               i_reg2_wr_en,
    input  logic               i_done,
    output logic [2*WIDTH-1:0] o_product,
    output logic               o_product_valid,
    output logic               o_busy
);
    localparam int PW = 2 * WIDTH;

    logic [PW-1:0]    r_reg_a, r_acc, r_product;
    logic [WIDTH-1:0] r_reg_b;
    logic             r_done_q, r_valid, r_busy;
    logic [WIDTH-1:0] w_mag_a, w_mag_b;
    logic [PW-1:0]    w_next_a, w_next_acc, w_result;
    logic [WIDTH-1:0] w_next_b;
    logic             w_load, w_capture;

    assign w_load    = i_reg_b_mode == 2'b11;
    assign w_capture = i_done & ~r_done_q;

`ifdef SIGNED_MULT_EN
    logic r_sign;

    assign w_mag_a  = i_operand_a[WIDTH-1] ? -i_operand_a : i_operand_a;
    assign w_mag_b  = i_operand_b[WIDTH-1] ? -i_operand_b : i_operand_b;
    assign w_result = r_sign ? -r_acc : r_acc;

    always_ff @(posedge i_clk) begin
        if (i_reset)
            r_sign <= 1'b0;
        else if (w_load)
            r_sign <= i_operand_a[WIDTH-1] ^ i_operand_b[WIDTH-1];
    end
`else
    assign w_mag_a  = i_operand_a;
    assign w_mag_b  = i_operand_b;
    assign w_result = r_acc;
`endif

    always_comb begin
        w_next_a   = i_reg_a_mode == 2'b11 ? {{WIDTH{1'b0}}, w_mag_a} :
                     i_reg_a_mode == 2'b01 ? r_reg_a << 1 :
                     i_reg_a_mode == 2'b10 ? r_reg_a >> 1 : r_reg_a;
        w_next_b   = i_reg_b_mode == 2'b11 ? w_mag_b :
                     i_reg_b_mode == 2'b01 ? r_reg_b << 1 :
                     i_reg_b_mode == 2'b10 ? r_reg_b >> 1 : r_reg_b;
        w_next_acc = !i_reg2_wr_en ? r_acc :
                     w_load        ? '0 :
                     r_acc + (r_reg_b[0] ? r_reg_a : '0);
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_reg_a   <= '0;
            r_reg_b   <= '0;
            r_acc     <= '0;
            r_product <= '0;
            r_valid   <= 1'b0;
            r_busy    <= 1'b0;
            r_done_q  <= 1'b1;
        end else begin
            r_reg_a   <= w_next_a;
            r_reg_b   <= w_next_b;
            r_acc     <= w_next_acc;
            r_done_q  <= i_done;
            r_valid   <= w_capture;
            r_product <= w_capture ? w_result : r_product;
            // a load on the capture edge starts a new run, so it keeps busy set
            r_busy    <= w_load ? 1'b1 : w_capture ? 1'b0 : r_busy;
        end
    end

    assign o_product       = r_product;
    assign o_product_valid = r_valid;
    assign o_busy          = r_busy;
endmodule

// File: tb/tb_mult_datapath.sv
// tb_mult_datapath: directed self-checking bench for mult_datapath.
module tb_mult_datapath;
    localparam int W = 16;

    logic           clk = 1'b0;
    logic           reset;
    logic [W-1:0]   operand_a, operand_b;
    logic [1:0]     a_mode, b_mode;
    logic           wr_en, done;
    logic [2*W-1:0] product;
    logic           product_valid, busy;
    int             errors = 0;
    int             checks = 0;

    always #5 clk = ~clk;

    mult_datapath #(.WIDTH(W)) dut (
        .i_clk(clk), .i_reset(reset), .i_operand_a(operand_a), .i_operand_b(operand_b),
        .i_reg_a_mode(a_mode), .i_reg_b_mode(b_mode), .i_reg2_wr_en(wr_en), .i_done(done),
        .o_product(product), .o_product_valid(product_valid), .o_busy(busy)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] am, input logic [1:0] bm, input logic wr, input logic dn);
        a_mode = am;
        b_mode = bm;
        wr_en  = wr;
        done   = dn;
    endtask

    task automatic load(input logic [W-1:0] a, input logic [W-1:0] b);
        operand_a = a;
        operand_b = b;
        drive(2'b11, 2'b11, 1'b1, 1'b0);
        step();
        check("busy_after_load", busy, 1'b1);
        operand_a = 'x;
        operand_b = 'x;
    endtask

    task automatic compute(input int n);
        drive(2'b01, 2'b10, 1'b1, 1'b0);
        repeat (n) step();
    endtask

    task automatic finish_run(input string tag, input logic [2*W-1:0] exp);
        check({tag, "_busy_pre"}, busy, 1'b1);
        check({tag, "_valid_pre"}, product_valid, 1'b0);
        drive(2'b00, 2'b00, 1'b0, 1'b1);
        step();
        check({tag, "_valid"}, product_valid, 1'b1);
        check({tag, "_product"}, product, exp);
        check({tag, "_busy_post"}, busy, 1'b0);
        step();
        check({tag, "_valid_once"}, product_valid, 1'b0);
        check({tag, "_product_hold"}, product, exp);
    endtask

    initial begin
        reset = 1'b1;
        operand_a = '0;
        operand_b = '0;
        drive(2'b00, 2'b00, 1'b0, 1'b1);
        step();
        check("rst_product", product, 32'h0);
        check("rst_valid", product_valid, 1'b0);
        check("rst_busy", busy, 1'b0);
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            check("idle_valid", product_valid, 1'b0);
            check("idle_product", product, 32'h0);
        end

        load(16'd3, 16'd5);
        compute(16);
        finish_run("mul_3x5", 32'h0000000F);

        load(16'hFFFF, 16'hFFFF);
        compute(17);
        finish_run("mul_max", 32'hFFFE0001);

        load(16'd7, 16'd9);
        compute(8);
        reset = 1'b1;
        step();
        check("abort_valid", product_valid, 1'b0);
        check("abort_product", product, 32'h0);
        check("abort_busy", busy, 1'b0);
        reset = 1'b0;
        drive(2'b00, 2'b00, 1'b0, 1'b1);
        step();
        check("abort_no_edge", product_valid, 1'b0);
        step();
        check("abort_no_edge2", product_valid, 1'b0);
        load(16'd2, 16'd6);
        compute(16);
        finish_run("mul_2x6", 32'd12);

        load(16'h1234, 16'h0000);
        compute(16);
        finish_run("mul_b0", 32'h0);
        load(16'h0000, 16'hABCD);
        compute(16);
        finish_run("mul_a0", 32'h0);

        load(16'd3, 16'd5);
        compute(16);
        operand_a = 16'd4;
        operand_b = 16'd5;
        drive(2'b11, 2'b11, 1'b1, 1'b1);
        step();
        check("overlap_valid", product_valid, 1'b1);
        check("overlap_product", product, 32'd15);
        check("overlap_busy", busy, 1'b1);
        compute(16);
        finish_run("mul_4x5", 32'd20);

`ifdef SIGNED_MULT_EN
        load(16'hFFFD, 16'd5);
        compute(16);
        finish_run("smul_neg3x5", 32'hFFFFFFF1);
        load(16'h8000, 16'h8000);
        compute(16);
        finish_run("smul_min", 32'h40000000);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
